online_softmax_ctrl: RTL
========================

ONLINE_SOFTMAX_CTRL -- requirements
Module: online_softmax_ctrl

Interface
REQ-001 The module SHALL be parameterized: CNT_W, default 8, width of the per-row element counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 s_vld  input  1  score/value pair valid.
REQ-005 s_rdy  output  1  controller can accept a pair.
REQ-006 s_score  input  INT_T  signed score q·k for the current key.
REQ-007 s_vec  input  STAR_VECTOR_T  value vector paired with s_score.
REQ-008 s_last  input  1  pair is the last of the current row.
REQ-009 em_vld  output  1  operation valid toward the expmul unit.
REQ-010 em_rdy  input  1  expmul unit ready (its rdy_out).
REQ-011 em_a, em_b  output  INT_T each  exponent operands; expmul computes exp(em_a - em_b) * em_v.
REQ-012 em_v  output  STAR_VECTOR_T  vector operand.
REQ-013 em_op  output  1  0 = rescale accumulator, 1 = accumulate new value.
REQ-014 done_vld  output  1  row result valid.
REQ-015 done_rdy  input  1  downstream accepts row result.
REQ-016 done_max  output  INT_T  final running max of the row.
REQ-017 done_cnt  output  CNT_W  number of pairs accepted in the row.

Function
REQ-018 The module SHALL implement FSM states IDLE, RESC, ACC, DONE; s_rdy SHALL be 1 only in IDLE.
REQ-019 s_vld&&s_rdy SHALL latch s_score, s_vec, s_last; compute m_new = first ? s_score : signed max(m, s_score); m_old = m.
- first = row element count is 0.
REQ-020 From IDLE on accept, next state SHALL be RESC if !first && m_new != m_old, else ACC.
REQ-021 In RESC: em_vld=1, em_op=0, em_a=m_old, em_b=m_new, em_v='0; on em_vld&&em_rdy go to ACC.
REQ-022 In ACC: em_vld=1, em_op=1, em_a=latched score, em_b=m_new, em_v=latched vector; on em_vld&&em_rdy:
- m <= m_new; count increments;
- go to DONE if latched last, else IDLE.
REQ-023 em_a/em_b/em_v/em_op SHALL hold stable while em_vld=1 and em_rdy=0.
REQ-024 In DONE: done_vld=1, done_max=m, done_cnt=count; on done_rdy go to IDLE and clear count to 0 and m to most-negative INT_T.
REQ-025 The count SHALL saturate at 2^CNT_W-1; further pairs SHALL still be processed.
REQ-026 Signed comparison SHALL be used; equal score does not trigger RESC.
REQ-027 em_vld SHALL be 0 in IDLE and DONE; done_vld SHALL be 0 outside DONE.
REQ-028 Minimum latency per non-first pair:
- accept -> ACC issue: 1 cycle without rescale, 2 cycles with rescale (em_rdy held 1).
REQ-029 A single-element row (first && last) SHALL issue one ACC op with em_a=em_b=score, then DONE with done_cnt=1.

Reset
REQ-030 rst asserted, at any time including mid-row, SHALL immediately force:
- state=IDLE, s_rdy=1, em_vld=0, done_vld=0;
- count=0, m=most-negative INT_T, all latched operands/outputs '0.
REQ-031 After rst deasserts, the first accepted pair SHALL be treated as the first of a new row.

Verification
REQ-032 Row scores 3,5,5,2 (last on 2), em_rdy=1 -> ops:
- ACC(3,3), RESC(3,5), ACC(5,5), ACC(5,5), ACC(2,5);
- done_max=5, done_cnt=4.
REQ-033 Single pair score -7, last=1 -> one ACC(-7,-7), em_op=1, then done_vld with done_max=-7, done_cnt=1.
REQ-034 em_rdy held 0 for 4 cycles during RESC -> em_vld=1 and operands stable all 4 cycles, s_rdy=0, no count change.
REQ-035 done_rdy held 0 for 3 cycles -> done_vld/done_max/done_cnt stable, s_rdy=0; new row starts only after done_rdy.
REQ-036 Negative scores -4,-1 -> RESC(-4,-1) issued; signed max is used (0xFFFC < 0xFFFF).
REQ-037 rst pulsed while in ACC with em_rdy=0 -> next cycle em_vld=0, s_rdy=1; next row's first pair produces no RESC.

Source files
------------

// File: rtl/online_softmax_ctrl.sv
// -----------------------------------------------------------------------------
// online_softmax_ctrl
// Sequencer for a streaming (online) softmax row. For every accepted
// score/value pair it keeps the running maximum of the row and issues up to
// two operations to an exp-multiply unit: an optional rescale of the
// accumulator when the maximum grows, followed by the accumulation of the new
// value weighted by exp(score - max). After the last pair of a row it presents
// the final maximum and the element count.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_vld/s_rdy       input pair handshake (s_score, s_vec, s_last)
//   em_vld/em_rdy     operation handshake toward expmul (em_a, em_b, em_v, em_op)
//                     em_op: 0 = rescale accumulator, 1 = accumulate value
//   done_vld/done_rdy row result handshake (done_max, done_cnt)
// -----------------------------------------------------------------------------
module online_softmax_ctrl #(
    parameter int CNT_W = 8,
    parameter int INT_W = 16,
    parameter int VEC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_vld,
    output logic                    s_rdy,
    input  logic signed [INT_W-1:0] s_score,
    input  logic [VEC_W-1:0]        s_vec,
    input  logic                    s_last,
    output logic                    em_vld,
    input  logic                    em_rdy,
    output logic signed [INT_W-1:0] em_a,
    output logic signed [INT_W-1:0] em_b,
    output logic [VEC_W-1:0]        em_v,
    output logic                    em_op,
    output logic                    done_vld,
    input  logic                    done_rdy,
    output logic signed [INT_W-1:0] done_max,
    output logic [CNT_W-1:0]        done_cnt
);

    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESC = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic signed [INT_W-1:0] m_r;          // running max of the current row
    logic [CNT_W-1:0]        cnt_r;        // pairs completed in the current row
    logic signed [INT_W-1:0] score_r;
    logic [VEC_W-1:0]        vec_r;
    logic                    last_r;
    logic signed [INT_W-1:0] m_new_r;      // max including the pair in flight

    logic                    first_s;
    logic signed [INT_W-1:0] m_new_s;
    logic                    resc_s;
    logic [CNT_W-1:0]        cnt_inc_s;

    // Candidate max for the incoming pair, rescale decision and saturating count.
    always_comb begin
        first_s   = (cnt_r == {CNT_W{1'b0}});
        m_new_s   = m_r;
        resc_s    = 1'b0;
        cnt_inc_s = cnt_r;
        if (first_s) begin
            m_new_s = s_score;
        end else if (s_score > m_r) begin
            m_new_s = s_score;
        end else begin
            m_new_s = m_r;
        end
        // An equal score leaves the max unchanged, so no rescale is needed.
        resc_s = !first_s && (m_new_s != m_r);
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Row FSM with all handshake outputs and operands registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            m_r      <= INT_MIN;
            cnt_r    <= {CNT_W{1'b0}};
            score_r  <= {INT_W{1'b0}};
            vec_r    <= {VEC_W{1'b0}};
            last_r   <= 1'b0;
            m_new_r  <= {INT_W{1'b0}};
            s_rdy    <= 1'b1;
            em_vld   <= 1'b0;
            em_a     <= {INT_W{1'b0}};
            em_b     <= {INT_W{1'b0}};
            em_v     <= {VEC_W{1'b0}};
            em_op    <= 1'b0;
            done_vld <= 1'b0;
            done_max <= {INT_W{1'b0}};
            done_cnt <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (s_vld && s_rdy) begin
                        score_r <= s_score;
                        vec_r   <= s_vec;
                        last_r  <= s_last;
                        m_new_r <= m_new_s;
                        s_rdy   <= 1'b0;
                        em_vld  <= 1'b1;
                        em_b    <= m_new_s;
                        if (resc_s) begin
                            state_r <= RESC;
                            em_op   <= 1'b0;
                            em_a    <= m_r;
                            em_v    <= {VEC_W{1'b0}};
                        end else begin
                            state_r <= ACC;
                            em_op   <= 1'b1;
                            em_a    <= s_score;
                            em_v    <= s_vec;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RESC: begin
                    if (em_rdy) begin
                        state_r <= ACC;
                        em_op   <= 1'b1;
                        em_a    <= score_r;
                        em_b    <= m_new_r;
                        em_v    <= vec_r;
                    end else begin
                        state_r <= RESC;
                    end
                end
                ACC: begin
                    if (em_rdy) begin
                        m_r    <= m_new_r;
                        cnt_r  <= cnt_inc_s;
                        em_vld <= 1'b0;
                        if (last_r) begin
                            state_r  <= DONE;
                            done_vld <= 1'b1;
                            done_max <= m_new_r;
                            done_cnt <= cnt_inc_s;
                        end else begin
                            state_r <= IDLE;
                            s_rdy   <= 1'b1;
                        end
                    end else begin
                        state_r <= ACC;
                    end
                end
                DONE: begin
                    if (done_rdy) begin
                        state_r  <= IDLE;
                        done_vld <= 1'b0;
                        s_rdy    <= 1'b1;
                        cnt_r    <= {CNT_W{1'b0}};
                        m_r      <= INT_MIN;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    s_rdy    <= 1'b1;
                    em_vld   <= 1'b0;
                    done_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
